// File: rtl/gamepad_pkg.sv
// Shared constants for the NES standard-controller ports at $4016/$4017.
// Button order matches the serial order a real controller shifts out.
package gamepad_pkg;

  localparam int KEY_W     = 8;
  localparam int NUM_PORTS = 2;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Open-bus high byte left on the CPU data bus by the $40xx read.
  localparam logic [7:0] GAMEPAD_OPEN_BUS = 8'h40;

  localparam logic [15:0] PORT0_ADDR = 16'h4016;
  localparam logic [15:0] PORT1_ADDR = 16'h4017;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  function automatic logic [7:0] read_byte(input logic bit0);
    return GAMEPAD_OPEN_BUS | {7'b0, bit0};
  endfunction

endpackage

// File: rtl/gamepad_shifter.sv
// One controller: 2-flop button synchronizer feeding an 8-bit parallel-load
// shift register that fills with 1s as bits are consumed.
module gamepad_shifter
  import gamepad_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_reload,
  input  logic             i_shift,
  input  logic [KEY_W-1:0] i_keys,
  output logic             o_bit0
);

  logic [KEY_W-1:0] r_sync1;
  logic [KEY_W-1:0] r_sync2;
  logic [KEY_W-1:0] r_sr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sr    <= '0;
    end else begin
      r_sync1 <= i_keys;
      r_sync2 <= r_sync1;
      // Reload wins over a shift landing in the same cycle.
      if (i_reload) begin
        r_sr <= r_sync2;
      end else if (i_shift) begin
        r_sr <= {1'b1, r_sr[KEY_W-1:1]};
      end
    end
  end

  assign o_bit0 = r_sr[BTN_A];

endmodule

// File: rtl/gamepad_ports.sv
// Two-port standard-controller block for the $4016/$4017 window: strobe
// register, read-completion edge detect, and the CPU read-data mux.
module gamepad_ports
  import gamepad_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             addr0,
  input  logic [7:0]       data_in,
  input  logic             gamepad_w,
  input  logic             gamepad_r,
  input  logic [KEY_W-1:0] pad0_keys,
  input  logic [KEY_W-1:0] pad1_keys,
  output logic [7:0]       gamepad_data
);

  logic  r_strobe;
  logic  r_d;
  port_e r_rd_port;
  logic  r_rd_blk;

  logic  w_rd_done;
  logic  w_shift0;
  logic  w_shift1;
  logic  w_bit0_p0;
  logic  w_bit0_p1;
  logic  w_unused;

  assign w_unused = &{1'b0, data_in[7:1]};

  // $4017 writes belong to the APU frame counter and are ignored here.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_strobe <= 1'b0;
    end else if (gamepad_w && (addr0 == PORT0)) begin
      r_strobe <= data_in[0];
    end
  end

  // r_rd_blk masks an access that was already under way when reset released,
  // so its trailing edge is not mistaken for a completed read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_d       <= 1'b0;
      r_rd_port <= PORT0;
      r_rd_blk  <= 1'b1;
    end else begin
      r_d <= gamepad_r;
      if (gamepad_r && !r_d) begin
        r_rd_port <= port_e'(addr0);
      end
      if (!gamepad_r) begin
        r_rd_blk <= 1'b0;
      end
    end
  end

  assign w_rd_done = r_d && !gamepad_r && !r_rd_blk;
  assign w_shift0  = w_rd_done && (r_rd_port == PORT0);
  assign w_shift1  = w_rd_done && (r_rd_port == PORT1);

  gamepad_shifter u_pad0 (
    .i_clk    (CLK),
    .i_rst    (RESET),
    .i_reload (r_strobe),
    .i_shift  (w_shift0),
    .i_keys   (pad0_keys),
    .o_bit0   (w_bit0_p0)
  );

  gamepad_shifter u_pad1 (
    .i_clk    (CLK),
    .i_rst    (RESET),
    .i_reload (r_strobe),
    .i_shift  (w_shift1),
    .i_keys   (pad1_keys),
    .o_bit0   (w_bit0_p1)
  );

  assign gamepad_data = read_byte((addr0 == PORT1) ? w_bit0_p1 : w_bit0_p0);

endmodule

// File: tb/tb_gamepad_ports.sv
// Directed bench for gamepad_ports: a read-count model of each controller
// is compared every cycle, plus literal expectations from the test plan.
module tb_gamepad_ports;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       addr0 = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       gamepad_w = 1'b0;
  logic       gamepad_r = 1'b0;
  logic [7:0] pad0_keys = 8'h00;
  logic [7:0] pad1_keys = 8'h00;
  logic [7:0] gamepad_data;

  int n_cmp = 0;
  int n_fail = 0;

  gamepad_ports dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .addr0        (addr0),
    .data_in      (data_in),
    .gamepad_w    (gamepad_w),
    .gamepad_r    (gamepad_r),
    .pad0_keys    (pad0_keys),
    .pad1_keys    (pad1_keys),
    .gamepad_data (gamepad_data)
  );

  always #5 CLK = ~CLK;

  // Model: each port holds the byte latched at the last strobe reload and the
  // number of completed reads since; bit0 is latched[count], or 1 once count>=8.
  logic [7:0] m_k1 [2];
  logic [7:0] m_k2 [2];
  logic [7:0] m_lat [2];
  int         m_cnt [2];
  logic       m_strobe;
  logic       m_rprev;
  logic       m_port;
  logic       m_blk;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int p = 0; p < 2; p++) begin
        m_k1[p]  <= 8'h00;
        m_k2[p]  <= 8'h00;
        m_lat[p] <= 8'h00;
        m_cnt[p] <= 0;
      end
      m_strobe <= 1'b0;
      m_rprev  <= 1'b0;
      m_port   <= 1'b0;
      m_blk    <= 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        m_k1[p] <= (p == 1) ? pad1_keys : pad0_keys;
        m_k2[p] <= m_k1[p];
        if (m_strobe) begin
          m_lat[p] <= m_k2[p];
          m_cnt[p] <= 0;
        end else if (m_rprev && !gamepad_r && !m_blk && (int'(m_port) == p) && m_cnt[p] < 8) begin
          m_cnt[p] <= m_cnt[p] + 1;
        end
      end
      if (gamepad_w && !addr0) m_strobe <= data_in[0];
      m_rprev <= gamepad_r;
      if (gamepad_r && !m_rprev) m_port <= addr0;
      if (!gamepad_r) m_blk <= 1'b0;
    end
  end

  function automatic logic [7:0] model_data(input logic a);
    int p;
    logic b;
    p = a ? 1 : 0;
    b = (m_cnt[p] >= 8) ? 1'b1 : m_lat[p][m_cnt[p][2:0]];
    return 8'h40 | {7'b0, b};
  endfunction

  always @(negedge CLK) begin
    if (!RESET) begin
      n_cmp++;
      if (gamepad_data !== model_data(addr0)) begin
        n_fail++;
        $display("FAIL model t=%0t: gamepad_data=%02h expected %02h", $time, gamepad_data, model_data(addr0));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] exp);
    @(negedge CLK);
    n_cmp++;
    if (gamepad_data !== exp) begin
      n_fail++;
      $display("FAIL %s: gamepad_data=%02h expected %02h", name, gamepad_data, exp);
    end
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    gamepad_w = 1'b1;
    addr0     = a;
    data_in   = d;
    step();
    gamepad_w = 1'b0;
    addr0     = 1'b0;
  endtask

  task automatic rd(input string name, input logic a, input int n, input logic [7:0] exp);
    gamepad_r = 1'b1;
    addr0     = a;
    for (int i = 0; i < n; i++) begin
      chk(name, exp);
      step();
    end
    gamepad_r = 1'b0;
    step();
  endtask

  task automatic strobe_pulse();
    wr(1'b0, 8'h01);
    repeat (3) step();
    wr(1'b0, 8'h00);
  endtask

  initial begin
    // Reset state and strobe-off behaviour
    chk("reset_data", 8'h40);
    step();
    step();
    RESET = 1'b0;
    step();
    rd("rd4016_after_reset", 1'b0, 1, 8'h40);
    pad0_keys = 8'hFF;
    repeat (3) step();
    chk("keys_ignored_strobe0", 8'h40);

    // Serial readout 1,0,1,0,0,0,0,1 then shifted-in 1s
    pad0_keys = 8'b1000_0101;
    pad1_keys = 8'b0000_0101;
    strobe_pulse();
    rd("p0_bit0", 1'b0, 1, 8'h41);
    rd("p0_bit1", 1'b0, 1, 8'h40);
    rd("p0_bit2", 1'b0, 1, 8'h41);
    rd("p0_bit3", 1'b0, 1, 8'h40);
    rd("p0_bit4", 1'b0, 1, 8'h40);
    rd("p0_bit5", 1'b0, 1, 8'h40);
    rd("p0_bit6", 1'b0, 1, 8'h40);
    rd("p0_bit7", 1'b0, 1, 8'h41);
    rd("p0_fill9", 1'b0, 1, 8'h41);
    rd("p0_fill10", 1'b0, 1, 8'h41);

    // Long access on $4017: stable data, single shift
    rd("p1_held_A", 1'b1, 4, 8'h41);
    rd("p1_after_held_B", 1'b1, 1, 8'h40);
    rd("p1_select", 1'b1, 1, 8'h41);

    // Strobe held high: reads return live A without advancing
    pad0_keys = 8'h01;
    wr(1'b0, 8'h01);
    repeat (3) step();
    rd("strobe_rd1", 1'b0, 1, 8'h41);
    rd("strobe_rd2", 1'b0, 1, 8'h41);
    rd("strobe_rd3", 1'b0, 1, 8'h41);
    pad0_keys = 8'h00;
    step();
    step();
    chk("release_A_2edges", 8'h41);
    step();
    chk("release_A_3edges", 8'h40);
    wr(1'b0, 8'h00);

    // Interleaved ports advance independently
    pad0_keys = 8'h02;
    pad1_keys = 8'h01;
    strobe_pulse();
    rd("inter_p0_a", 1'b0, 1, 8'h40);
    rd("inter_p1_a", 1'b1, 1, 8'h41);
    rd("inter_p0_b", 1'b0, 1, 8'h41);

    // $4017 write leaves strobe alone: no reload of new keys
    wr(1'b1, 8'h01);
    pad0_keys = 8'hFF;
    repeat (4) step();
    rd("w4017_ignored", 1'b0, 1, 8'h40);

    // Reset in the middle of a held read; the aborted access never shifts
    gamepad_r = 1'b1;
    addr0     = 1'b0;
    step();
    step();
    RESET = 1'b1;
    chk("rst_mid_access", 8'h40);
    step();
    step();
    RESET = 1'b0;
    step();
    gamepad_r = 1'b0;
    step();
    step();
    for (int i = 0; i < 8; i++) rd("post_rst_zero", 1'b0, 1, 8'h40);
    rd("post_rst_fill", 1'b0, 1, 8'h41);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
